// File: rtl/microwave_cook_controller_if.sv
// Panel/timer/countdown signal bundle for the microwave cook controller.
// Optional MICROWAVE_LAMP_EN adds the oven lamp output.
interface microwave_cook_controller_if;
    logic       key_pressed;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic       timer_zero;
    logic       pgt_1Hz;
    logic       enablen;
    logic       count_enablen;
    logic       clear_timern;
    logic       mag_on;
    logic       beep;
    logic [2:0] state;
`ifdef MICROWAVE_LAMP_EN
    logic       lamp;

    modport master (
        output key_pressed, start, stop, clear, door_closed, timer_zero, pgt_1Hz,
        input  enablen, count_enablen, clear_timern, mag_on, beep, state, lamp
    );
    modport slave (
        input  key_pressed, start, stop, clear, door_closed, timer_zero, pgt_1Hz,
        output enablen, count_enablen, clear_timern, mag_on, beep, state, lamp
    );
`else
    modport master (
        output key_pressed, start, stop, clear, door_closed, timer_zero, pgt_1Hz,
        input  enablen, count_enablen, clear_timern, mag_on, beep, state
    );
    modport slave (
        input  key_pressed, start, stop, clear, door_closed, timer_zero, pgt_1Hz,
        output enablen, count_enablen, clear_timern, mag_on, beep, state
    );
`endif
endinterface

// File: rtl/microwave_cook_controller.sv
// Moore operating sequencer for the microwave oven (IDLE/ENTRY/COOK/PAUSE/DONE).
// Optional feature macro: MICROWAVE_LAMP_EN (registered oven lamp output).
module microwave_cook_controller #(
    parameter int BEEP_SECONDS = 3,
    parameter int CNT_W        = 4
) (
    input  logic                               clock_100Hz,
    input  logic                               resetn,
    microwave_cook_controller_if.slave         bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               clr_pulse_s;

    logic               start_prev_r, stop_prev_r, clear_prev_r, key_prev_r, pgt_prev_r;
    logic               start_rise_s, stop_rise_s, clear_rise_s, key_rise_s, pgt_rise_s;

    logic               enablen_r, count_enablen_r, clear_timern_r, mag_on_r, beep_r;
    logic               enablen_s, count_enablen_s, mag_on_s, beep_s;

    assign start_rise_s = bus.start       & ~start_prev_r;
    assign stop_rise_s  = bus.stop        & ~stop_prev_r;
    assign clear_rise_s = bus.clear       & ~clear_prev_r;
    assign key_rise_s   = bus.key_pressed & ~key_prev_r;
    assign pgt_rise_s   = bus.pgt_1Hz     & ~pgt_prev_r;

    // Edge-detect history; loads during reset so a held input yields no edge.
    always_ff @(posedge clock_100Hz) begin
        start_prev_r <= bus.start;
        stop_prev_r  <= bus.stop;
        clear_prev_r <= bus.clear;
        key_prev_r   <= bus.key_pressed;
        pgt_prev_r   <= bus.pgt_1Hz;
    end

    // State, beep counter and registered output flops.
    always_ff @(posedge clock_100Hz) begin
        if (!resetn) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            enablen_r       <= 1'b0;
            count_enablen_r <= 1'b1;
            clear_timern_r  <= 1'b0;
            mag_on_r        <= 1'b0;
            beep_r          <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            cnt_r           <= cnt_next_s;
            enablen_r       <= enablen_s;
            count_enablen_r <= count_enablen_s;
            clear_timern_r  <= ~clr_pulse_s;
            mag_on_r        <= mag_on_s;
            beep_r          <= beep_s;
        end
    end

    // Next-state logic; the first matching branch in each state wins.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        clr_pulse_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (key_rise_s) next_state_s = ST_ENTRY;
                else            next_state_s = ST_IDLE;
            end
            ST_ENTRY: begin
                if (clear_rise_s) begin
                    next_state_s = ST_IDLE;
                    clr_pulse_s  = 1'b1;
                end else if (start_rise_s && bus.door_closed && !bus.timer_zero) begin
                    next_state_s = ST_COOK;
                end else begin
                    next_state_s = ST_ENTRY;
                end
            end
            ST_COOK: begin
                if (clear_rise_s) begin
                    next_state_s = ST_IDLE;
                    clr_pulse_s  = 1'b1;
                end else if (stop_rise_s || !bus.door_closed) begin
                    next_state_s = ST_PAUSE;
                end else if (bus.timer_zero) begin
                    next_state_s = ST_DONE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    next_state_s = ST_COOK;
                end
            end
            ST_PAUSE: begin
                if (clear_rise_s) begin
                    next_state_s = ST_IDLE;
                    clr_pulse_s  = 1'b1;
                end else if (start_rise_s && bus.door_closed) begin
                    if (!bus.timer_zero) begin
                        next_state_s = ST_COOK;
                    end else begin
                        next_state_s = ST_DONE;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    next_state_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (clear_rise_s) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                    clr_pulse_s  = 1'b1;
                end else if (stop_rise_s || !bus.door_closed) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (pgt_rise_s) begin
                    if (cnt_r + CNT_W'(1) == CNT_W'(BEEP_SECONDS)) begin
                        next_state_s = ST_IDLE;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(1);
                    end
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Moore output decode of the upcoming state so the flops match the state register.
    always_comb begin
        enablen_s       = 1'b0;
        count_enablen_s = 1'b1;
        mag_on_s        = 1'b0;
        beep_s          = 1'b0;
        case (next_state_s)
            ST_IDLE, ST_ENTRY: begin
                enablen_s = 1'b0;
            end
            ST_COOK: begin
                enablen_s       = 1'b1;
                count_enablen_s = 1'b0;
                mag_on_s        = 1'b1;
            end
            ST_PAUSE: begin
                enablen_s = 1'b1;
            end
            ST_DONE: begin
                enablen_s = 1'b1;
                beep_s    = 1'b1;
            end
            default: begin
                enablen_s = 1'b0;
            end
        endcase
    end

    assign bus.state         = state_r;
    assign bus.enablen       = enablen_r;
    assign bus.count_enablen = count_enablen_r;
    assign bus.clear_timern  = clear_timern_r;
    assign bus.mag_on        = mag_on_r;
    assign bus.beep          = beep_r;

`ifdef MICROWAVE_LAMP_EN
    logic lamp_r;

    // Lamp lights with the door open or whenever the oven is in an active cycle.
    always_ff @(posedge clock_100Hz) begin
        if (!resetn) begin
            lamp_r <= 1'b0;
        end else begin
            lamp_r <= ~bus.door_closed | (next_state_s == ST_COOK) |
                      (next_state_s == ST_PAUSE) | (next_state_s == ST_DONE);
        end
    end

    assign bus.lamp = lamp_r;
`endif
endmodule

// File: tb/tb_microwave_cook_controller.sv
// Directed self-checking bench for microwave_cook_controller (BEEP_SECONDS=3).
module tb_microwave_cook_controller;
    logic clk = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_miss = 0;

    microwave_cook_controller_if bus ();

    microwave_cook_controller #(.BEEP_SECONDS(3), .CNT_W(4)) dut (
        .clock_100Hz (clk),
        .resetn      (resetn),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn           = 1'b0;
        bus.start        = 1'b1;
        bus.stop         = 1'b0;
        bus.clear        = 1'b0;
        bus.key_pressed  = 1'b0;
        bus.door_closed  = 1'b1;
        bus.timer_zero   = 1'b0;
        bus.pgt_1Hz      = 1'b0;
        tick(); tick();
        chk("rst_state",   {5'd0, bus.state}, 8'd0);
        chk("rst_enablen", {7'd0, bus.enablen}, 8'd0);
        chk("rst_cnten",   {7'd0, bus.count_enablen}, 8'd1);
        chk("rst_clrn",    {7'd0, bus.clear_timern}, 8'd0);
        chk("rst_mag",     {7'd0, bus.mag_on}, 8'd0);
        chk("rst_beep",    {7'd0, bus.beep}, 8'd0);

        // start held across reset release must not register as an edge
        resetn = 1'b1;
        tick();
        chk("rel_state", {5'd0, bus.state}, 8'd0);
        chk("rel_clrn",  {7'd0, bus.clear_timern}, 8'd1);
        chk("rel_mag",   {7'd0, bus.mag_on}, 8'd0);
        bus.start = 1'b0;
        tick();

        bus.key_pressed = 1'b1; tick();
        chk("key_entry", {5'd0, bus.state}, 8'd1);
        bus.key_pressed = 1'b0;
        bus.timer_zero = 1'b1; bus.start = 1'b1; tick();
        chk("entry_tz_stay", {5'd0, bus.state}, 8'd1);
        bus.start = 1'b0; bus.timer_zero = 1'b0; bus.door_closed = 1'b0; tick();
        bus.start = 1'b1; tick();
        chk("entry_door_stay", {5'd0, bus.state}, 8'd1);
        bus.start = 1'b0; bus.door_closed = 1'b1; tick();
        bus.start = 1'b1; tick();
        chk("cook_state", {5'd0, bus.state}, 8'd2);
        chk("cook_mag",   {7'd0, bus.mag_on}, 8'd1);
        chk("cook_cnten", {7'd0, bus.count_enablen}, 8'd0);
        chk("cook_en",    {7'd0, bus.enablen}, 8'd1);
        bus.start = 1'b0;
        bus.timer_zero = 1'b1; tick();
        chk("done_state", {5'd0, bus.state}, 8'd4);
        chk("done_beep",  {7'd0, bus.beep}, 8'd1);
        chk("done_mag",   {7'd0, bus.mag_on}, 8'd0);
        bus.timer_zero = 1'b0;

        // three 1 Hz rises with a 50-cycle half period
        for (int r = 1; r <= 3; r++) begin
            bus.pgt_1Hz = 1'b0;
            repeat (49) tick();
            chk("dwell_pre", {7'd0, bus.beep}, 8'd1);
            bus.pgt_1Hz = 1'b1; tick();
            if (r < 3) begin
                chk("dwell_mid_state", {5'd0, bus.state}, 8'd4);
                chk("dwell_mid_beep",  {7'd0, bus.beep}, 8'd1);
            end else begin
                chk("dwell_end_state", {5'd0, bus.state}, 8'd0);
                chk("dwell_end_beep",  {7'd0, bus.beep}, 8'd0);
            end
            repeat (49) tick();
        end
        bus.pgt_1Hz = 1'b0;

        bus.key_pressed = 1'b1; tick();
        bus.key_pressed = 1'b0; bus.start = 1'b1; tick();
        chk("cook2_state", {5'd0, bus.state}, 8'd2);
        bus.start = 1'b0;
        bus.door_closed = 1'b0; tick();
        chk("door_pause", {5'd0, bus.state}, 8'd3);
        chk("door_mag",   {7'd0, bus.mag_on}, 8'd0);
        bus.start = 1'b1; tick();
        chk("open_start_stay", {5'd0, bus.state}, 8'd3);
        bus.start = 1'b0; tick();
        bus.door_closed = 1'b1; tick();
        bus.start = 1'b1; tick();
        chk("resume_state", {5'd0, bus.state}, 8'd2);
        chk("resume_mag",   {7'd0, bus.mag_on}, 8'd1);
        bus.start = 1'b0;

        bus.stop = 1'b1; tick();
        chk("stop_pause", {5'd0, bus.state}, 8'd3);
        bus.stop = 1'b0; tick();
        bus.stop = 1'b1; bus.clear = 1'b1; tick();
        chk("clr_state", {5'd0, bus.state}, 8'd0);
        chk("clr_pulse", {7'd0, bus.clear_timern}, 8'd0);
        bus.stop = 1'b0; bus.clear = 1'b0; tick();
        chk("clr_pulse_end", {7'd0, bus.clear_timern}, 8'd1);

        bus.key_pressed = 1'b1; tick();
        bus.key_pressed = 1'b0; bus.start = 1'b1; tick();
        chk("cook3_state", {5'd0, bus.state}, 8'd2);
`ifdef MICROWAVE_LAMP_EN
        chk("lamp_cook", {7'd0, bus.lamp}, 8'd1);
`endif
        bus.start = 1'b0;
        resetn = 1'b0; tick();
        chk("midrst_state", {5'd0, bus.state}, 8'd0);
        chk("midrst_mag",   {7'd0, bus.mag_on}, 8'd0);
`ifdef MICROWAVE_LAMP_EN
        chk("lamp_rst", {7'd0, bus.lamp}, 8'd0);
`endif
        resetn = 1'b1; tick();
        chk("postrst_state", {5'd0, bus.state}, 8'd0);
`ifdef MICROWAVE_LAMP_EN
        bus.door_closed = 1'b0; tick();
        chk("lamp_door", {7'd0, bus.lamp}, 8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/microwave_cook_controller.md
Name: microwave_cook_controller

Overview:
- Top-level operating sequencer for the microwave oven.
- Consumes button, door and countdown-status inputs; drives enablen of the timer input and control module, the countdown enable, the timer clear and the magnetron/beeper outputs.
- Moore FSM clocked on the system 100 Hz clock; uses the 1 Hz square wave (pgt_1Hz) for the end-of-cook beep duration.

Parameters:
- BEEP_SECONDS, 3, number of pgt_1Hz rising edges the beeper stays on in DONE (range 1..15).
- CNT_W, 4, width of the internal beep counter; must hold BEEP_SECONDS.

Ports:
- clock_100Hz  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- key_pressed  input  1  high while any numpad key is held.
- start  input  1  start button, active high.
- stop  input  1  stop/pause button, active high.
- clear  input  1  clear button, active high.
- door_closed  input  1  1 = door closed.
- timer_zero  input  1  1 = countdown value is 00:00.
- pgt_1Hz  input  1  1 Hz square wave from the timer input module.
- enablen  output  1  0 = numpad entry allowed (to timer input module).
- count_enablen  output  1  0 = countdown decrements on its 1 Hz tick.
- clear_timern  output  1  one-cycle low pulse clearing the countdown.
- mag_on  output  1  magnetron on.
- beep  output  1  beeper on.
- state  output  3  current state code, for debug/display.

Behaviour:
- Reset: clock_100Hz edge with resetn=0 -> state=IDLE; enablen=0, count_enablen=1, clear_timern=0 (clear asserted during reset), mag_on=0, beep=0, beep counter=0.
- Edge detectors for start, stop, clear, key_pressed and pgt_1Hz: prev registers load the current input during reset. An input held high across reset release therefore produces no edge. rise = in & ~prev.
- Latency: an input rise sampled at edge k changes state at edge k. Outputs decode from the state register (Moore), so they are valid after edge k.
- State codes: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4. Codes 5–7 go to IDLE on the next edge.
- Outputs per state:
  - IDLE: enablen=0, count_enablen=1, mag_on=0, beep=0.
  - ENTRY: enablen=0, count_enablen=1, mag_on=0, beep=0.
  - COOK: enablen=1, count_enablen=0, mag_on=1, beep=0.
  - PAUSE: enablen=1, count_enablen=1, mag_on=0, beep=0.
  - DONE: enablen=1, count_enablen=1, mag_on=0, beep=1.
- clear_timern is 1 except for exactly one cycle following any transition caused by clear_rise.
- Transitions, listed in priority order within each state:
  - IDLE: key_rise -> ENTRY. start_rise is ignored (time is zero).
  - ENTRY: clear_rise -> IDLE (clear pulse). start_rise & door_closed & ~timer_zero -> COOK. start_rise with door open or timer_zero -> stay.
  - COOK: clear_rise -> IDLE (clear pulse, magnetron off). stop_rise or ~door_closed -> PAUSE. timer_zero -> DONE (beep counter=0).
  - PAUSE: clear_rise -> IDLE (clear pulse). start_rise & door_closed -> COOK if ~timer_zero, else DONE.
  - DONE: clear_rise, stop_rise or ~door_closed -> IDLE. Each pgt_1Hz rise increments the beep counter; when it reaches BEEP_SECONDS -> IDLE, counter=0.
- Simultaneous rises: clear beats stop, stop beats start, per the lists above.
- mag_on never asserts while door_closed=0. A door opening in COOK drops mag_on on the same edge that samples it.
- resetn=0 mid-cook -> IDLE and mag_on=0 after that edge, regardless of other inputs.

Optional Feature:
- Macro: MICROWAVE_LAMP_EN.
- Defined: adds output port lamp (1 bit), registered. lamp=1 when ~door_closed or state is COOK, PAUSE or DONE; lamp=0 on reset.
- Undefined: no lamp port and no lamp logic. All other behaviour is identical.

Test Plan:
- Reset release with start held high -> state stays 0, no edge detected; enablen=0, mag_on=0, clear_timern returns to 1 after the first edge with resetn=1.
- key_pressed pulse -> state=1. door_closed=1, timer_zero=0, start pulse -> state=2, mag_on=1, count_enablen=0 on the same sampled edge. timer_zero=1 -> state=4, beep=1.
- Full DONE dwell: in DONE with BEEP_SECONDS=3, apply 3 pgt_1Hz rising edges (50-cycle half period) -> beep stays 1 until the third rise, then state=0, beep=0.
- COOK with door_closed dropped to 0 -> PAUSE, mag_on=0. start while door open -> stays 3. Close door, then start -> state=2.
- In PAUSE, assert stop and clear on the same edge -> IDLE, with clear_timern low for exactly one cycle.
- Reset mid-COOK (resetn=0 for 1 cycle) -> state=0, mag_on=0. With MICROWAVE_LAMP_EN defined: lamp=1 in COOK and with door open in IDLE, lamp=0 after reset.
